// File: rtl/dmem_write_buffer.sv
// ---------------------------------------------------------------------------
// dmem_write_buffer
//
// Posted-write store buffer that sits between the core data port and a slow
// data memory. Stores retire into a circular FIFO and drain in order onto the
// memory write port. Loads are ordered behind every earlier buffered store.
//
// Optional feature (macro DMEM_WB_FWD_EN): loads that hit a buffered entry
// return the youngest matching data without draining or reading memory.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cpu_wen / cpu_ren     core store / load request (never both high)
//   cpu_addr, cpu_wdata   core word address and store data
//   cpu_rdata             load data, valid in the cycle cpu_stall falls
//   cpu_stall             core holds its request while high
//   mem_wen / mem_ren     registered memory write / read strobes
//   mem_addr, mem_wdata   registered memory address and write data
//   mem_rdata, mem_ready  memory read data and one-cycle completion pulse
// ---------------------------------------------------------------------------
module dmem_write_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 30,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_wen,
   input  logic          cpu_ren,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   output logic          mem_wen,
   output logic          mem_ren,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready
);

   localparam int          PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_READ  = 2'd2
   } state_e;

   logic [AW-1:0] fifo_addr_q [DEPTH];
   logic [DW-1:0] fifo_data_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW:0]   count_q, count_d;
   state_e        state_q;
   logic          mem_wen_q, mem_ren_q, load_done_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q, cpu_rdata_q;

   logic          enq_s, deq_s, hit_s, match_s;
   logic          load_stall_s, store_stall_s;
   logic [DW-1:0] fwd_data_s;
   logic [PW-1:0] head1_s;
   logic [AW-1:0] nxt_addr_s;
   logic [DW-1:0] nxt_data_s;

   // Enqueue/dequeue qualifiers and next pointer/occupancy values.
   always_comb begin
      deq_s    = (state_q == ST_DRAIN) && mem_ready;
      // A full buffer still accepts a store in the cycle the head retires.
      enq_s    = cpu_wen && ((count_q != FULL_CNT) || deq_s);
      rd_ptr_d = deq_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
      wr_ptr_d = enq_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
      case ({enq_s, deq_s})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Entry that follows the current head; with one entry left it can only be
   // the store arriving in this same cycle, which is not in the array yet.
   always_comb begin
      head1_s = rd_ptr_q + PW'(1);
      if (count_q > (PW+1)'(1)) begin
         nxt_addr_s = fifo_addr_q[head1_s];
         nxt_data_s = fifo_data_q[head1_s];
      end else begin
         nxt_addr_s = cpu_addr;
         nxt_data_s = cpu_wdata;
      end
   end

   // Load-hit search; walking oldest to youngest lets the youngest match win.
   always_comb begin
      hit_s      = 1'b0;
      match_s    = 1'b0;
      fwd_data_s = '0;
`ifdef DMEM_WB_FWD_EN
      for (int k = 0; k < DEPTH; k++) begin
         match_s    = ((PW+1)'(k) < count_q) &&
                      (fifo_addr_q[rd_ptr_q + PW'(k)] == cpu_addr);
         hit_s      = hit_s | (match_s & cpu_ren);
         fwd_data_s = match_s ? fifo_data_q[rd_ptr_q + PW'(k)] : fwd_data_s;
      end
`endif
   end

   // Core stall: pending load, or store into a full buffer with no retirement.
   always_comb begin
      load_stall_s  = cpu_ren && !hit_s && !load_done_q;
      store_stall_s = cpu_wen && (count_q == FULL_CNT) && !deq_s;
      cpu_stall     = rst_n && (load_stall_s || store_stall_s);
   end

   // FIFO storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_addr_q[i] <= '0;
            fifo_data_q[i] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (enq_s) begin
            fifo_addr_q[wr_ptr_q] <= cpu_addr;
            fifo_data_q[wr_ptr_q] <= cpu_wdata;
         end
      end
   end

   // Memory-side state machine with registered request and load-data outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mem_wen_q   <= 1'b0;
         mem_ren_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_rdata_q <= '0;
         load_done_q <= 1'b0;
      end else begin
         // load_done_q marks the single cycle in which a completed load is
         // released, so the still-asserted cpu_ren does not reissue it.
         load_done_q <= 1'b0;
         if (hit_s) begin
            cpu_rdata_q <= fwd_data_s;
         end
         case (state_q)
            ST_IDLE: begin
               if (count_q != '0) begin
                  state_q     <= ST_DRAIN;
                  mem_wen_q   <= 1'b1;
                  mem_addr_q  <= fifo_addr_q[rd_ptr_q];
                  mem_wdata_q <= fifo_data_q[rd_ptr_q];
               end else if (cpu_ren && !hit_s && !load_done_q) begin
                  state_q    <= ST_READ;
                  mem_ren_q  <= 1'b1;
                  mem_addr_q <= cpu_addr;
               end
            end
            ST_DRAIN: begin
               if (mem_ready) begin
                  if (count_d != '0) begin
                     mem_addr_q  <= nxt_addr_s;
                     mem_wdata_q <= nxt_data_s;
                  end else begin
                     mem_wen_q <= 1'b0;
                     state_q   <= ST_IDLE;
                  end
               end
            end
            ST_READ: begin
               if (mem_ready) begin
                  cpu_rdata_q <= mem_rdata;
                  load_done_q <= 1'b1;
                  mem_ren_q   <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               mem_wen_q <= 1'b0;
               mem_ren_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem_wen   = mem_wen_q;
   assign mem_ren   = mem_ren_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_rdata = cpu_rdata_q;

endmodule

// File: doc/dmem_write_buffer.md
Name: dmem_write_buffer

Overview:
- Posted-write store buffer between the RISC-V core data port and the slow data memory.
- Core stores retire into a FIFO without waiting on memory. The buffer drains the FIFO in order onto the memory write port, which is the write stream the testbench monitor snoops (word address, wdata, wen).
- Loads are ordered behind all earlier buffered stores.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 30, word address width.
- DW, 32, data width; data is passed through unmodified in little-endian byte order.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_wen  in  1  store request.
- cpu_ren  in  1  load request. Never asserted together with cpu_wen.
- cpu_addr  in  AW  word address.
- cpu_wdata  in  DW  store data.
- cpu_rdata  out  DW  load data; valid in the cycle cpu_stall falls after a load.
- cpu_stall  out  1  core must hold its request and PC while high.
- mem_wen  out  1  memory write strobe.
- mem_ren  out  1  memory read strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid with mem_ready.
- mem_ready  in  1  one-cycle completion pulse for the current request.

Behaviour:
- Reset values (asynchronous): FIFO empty; rd_ptr = wr_ptr = 0; count = 0; state IDLE; mem_wen = mem_ren = 0; mem_addr = 0; mem_wdata = 0; cpu_rdata = 0; cpu_stall = 0.
- FIFO: circular, pointers wrap modulo DEPTH; count ranges 0..DEPTH.
  - Enqueue at the edge when cpu_wen && count < DEPTH.
  - Dequeue at the edge when state is DRAIN && mem_ready.
  - Simultaneous enqueue and dequeue: count unchanged; both pointers advance.
- Store path, empty or partially full: a store accepts in the same cycle; cpu_stall stays 0.
- Store path, full: when cpu_wen && count == DEPTH, cpu_stall = 1 combinationally.
  - In the cycle mem_ready retires the head, the store is accepted and cpu_stall = 0.
- State machine, registered memory outputs:
  - IDLE:
    - count > 0 -> DRAIN; head entry is driven onto mem_addr/mem_wdata and mem_wen = 1.
    - Otherwise, cpu_ren -> READ; mem_ren = 1 and mem_addr = cpu_addr.
  - DRAIN: hold mem_wen/addr/wdata stable until mem_ready.
    - On mem_ready, dequeue.
    - If entries remain, including one enqueued the same cycle, load the next head and stay in DRAIN; that is a back-to-back write with no idle cycle.
    - Otherwise drop mem_wen and go to IDLE.
  - READ: hold mem_ren/addr until mem_ready.
    - On mem_ready, register cpu_rdata = mem_rdata, drop mem_ren, go to IDLE.
- Load ordering: cpu_stall = 1 whenever cpu_ren is high and the load has not yet completed, including while older stores drain. A load always waits for count == 0 before issuing.
- Write latency: an accepted store reaches mem_wen no earlier than 1 cycle later.
- Memory protocol: mem_wen and mem_ren are never high together. Request signals never change while a request is outstanding.
- Reset mid-operation: outstanding memory request is abandoned; strobes drop asynchronously; buffered stores are discarded.

Optional Feature:
- Macro: DMEM_WB_FWD_EN.
- Defined:
  - A load whose address matches any valid entry returns the youngest matching entry's data without draining and without a memory read.
  - cpu_stall is 0 for that load; cpu_rdata updates the next cycle.
  - A miss behaves as in Behaviour: drain, then read.
- Undefined: no address compare; every load drains the buffer, then reads memory.

Test Plan:
- Reset: assert rst_n = 0 mid-DRAIN -> mem_wen = 0 and cpu_stall = 0 immediately; count = 0 after release; no further mem_wen.
- Burst stores: 4 stores, addr 6..9, data 0x11..0x44, mem_ready after 3 cycles each -> cpu_stall never high; memory sees writes 6,7,8,9 in order with matching data.
- Full: 5 back-to-back stores with DEPTH = 4 and slow memory -> 5th store stalls until the first mem_ready, then is accepted; the write sequence is intact.
- RAW: store 0x000000AB to addr 13, then load addr 13 with the macro off -> mem_wen(13) precedes mem_ren(13); cpu_rdata = memory value after the write.
- Forwarding with DMEM_WB_FWD_EN: stores 0x5 then 0x7 to addr 10, then load 10 -> cpu_rdata = 0x7; no mem_ren issued.
- End marker: store to addr 134 after array stores -> it appears last on mem_wen, after all earlier writes.
